// File: rtl/lr_pass_controller.sv
// Three-pass sequencer for the linear-regression datapath.
// Pass 1 streams every sample into the sum accumulators and then loads the
// means. Pass 2 streams into ssXY/ssXX and then loads b1 followed by b0.
// Pass 3 streams into the residual-error accumulator and then pulses done.
// Samples are fetched one at a time with a mem_rd / mem_valid handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, aborts any run in progress
//   start      begin a run (sampled only in IDLE)
//   mem_rd     one-cycle read request for mem_addr
//   mem_addr   sample index (registered)
//   mem_valid  read data valid, latency >= 1 cycle after mem_rd
//   init_acc   clear all accumulators
//   acc_sum    pass-1 accumulate enable (combinational, WAIT && mem_valid)
//   acc_ss     pass-2 accumulate enable (combinational, WAIT && mem_valid)
//   acc_err    pass-3 accumulate enable (combinational, WAIT && mem_valid)
//   load_mean  load mean_x / mean_y
//   load_b1    load slope
//   load_b0    load intercept
//   pass       0 idle, 1..3 active pass (registered)
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
module lr_pass_controller #(
  parameter int unsigned N_SAMPLES = 150,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              init_acc,
  output logic              acc_sum,
  output logic              acc_ss,
  output logic              acc_err,
  output logic              load_mean,
  output logic              load_b1,
  output logic              load_b0,
  output logic [1:0]        pass,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD,
    WAIT,
    END1,
    END2,
    B0,
    END3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pass_q, pass_d;
  logic              last;

  // State, address and pass registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic and the Mealy accumulate enables.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    acc_sum = 1'b0;
    acc_ss  = 1'b0;
    acc_err = 1'b0;
    // Compare against the last index instead of incrementing past it, so a
    // full 2^ADDR_W pass stops at all-ones without wrapping.
    last    = (addr_q == LAST_ADDR);

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        addr_d  = '0;
        pass_d  = 2'd1;
        state_d = RD;
      end
      RD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          acc_sum = (pass_q == 2'd1);
          acc_ss  = (pass_q == 2'd2);
          acc_err = (pass_q == 2'd3);
          if (last) begin
            case (pass_q)
              2'd1:    state_d = END1;
              2'd2:    state_d = END2;
              default: state_d = END3;
            endcase
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD;
          end
        end
      end
      END1: begin
        addr_d  = '0;
        pass_d  = 2'd2;
        state_d = RD;
      end
      END2: begin
        state_d = B0;
      end
      // b0 = mean_y - b1*mean_x, so it loads the cycle after b1.
      B0: begin
        addr_d  = '0;
        pass_d  = 2'd3;
        state_d = RD;
      end
      END3: begin
        pass_d  = 2'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore strobes registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      init_acc  <= 1'b0;
      load_mean <= 1'b0;
      load_b1   <= 1'b0;
      load_b0   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd    <= (state_d == RD);
      init_acc  <= (state_d == INIT);
      load_mean <= (state_d == END1);
      load_b1   <= (state_d == END2);
      load_b0   <= (state_d == B0);
      busy      <= (state_d != IDLE);
      done      <= (state_d == END3);
    end
  end

  assign mem_addr = addr_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_lr_pass_controller.sv
// Self-checking bench for lr_pass_controller. Three instances (N=150, N=1,
// N=256) share one clock; a single stimulus thread drives the active one,
// models a variable-latency sample memory and scores every accumulate
// enable against a queue of expected {pass, address} records.
module tb_lr_pass_controller;

  localparam int unsigned AW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     [NI];
  logic          start     [NI];
  logic          mem_valid [NI];
  logic          mem_rd    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic          init_acc  [NI];
  logic          acc_sum   [NI];
  logic          acc_ss    [NI];
  logic          acc_err   [NI];
  logic          load_mean [NI];
  logic          load_b1   [NI];
  logic          load_b0   [NI];
  logic [1:0]    pass_s    [NI];
  logic          busy      [NI];
  logic          done      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NS = (g == 0) ? 150 : ((g == 1) ? 1 : 256);
    lr_pass_controller #(.N_SAMPLES(NS), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset[g]),
      .start     (start[g]),
      .mem_rd    (mem_rd[g]),
      .mem_addr  (mem_addr[g]),
      .mem_valid (mem_valid[g]),
      .init_acc  (init_acc[g]),
      .acc_sum   (acc_sum[g]),
      .acc_ss    (acc_ss[g]),
      .acc_err   (acc_err[g]),
      .load_mean (load_mean[g]),
      .load_b1   (load_b1[g]),
      .load_b0   (load_b0[g]),
      .pass      (pass_s[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  typedef struct packed {
    logic [1:0]    p;
    logic [AW-1:0] a;
  } exp_t;

  typedef struct {
    int inst;
    int n;
    int lmin;
    int lmax;
    int exp_lat;  // INIT..END3 cycle count, -1 when latency is random
    int stray;    // inject stray mem_valid / mid-pass-2 start
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int   cur, lmin, lmax, cyc, cd, acc_total;
  logic mv_next, mv_cur, extra_next, spulse_next, spulse_chk;
  logic stray_req, stray_auto, start_auto, start_req, reset_req, outst;
  logic s_busy, s_mem_rd, s_acc;
  logic [1:0]    s_pass;
  logic [AW-1:0] s_addr;
  int   c_sum, c_ss, c_err, n_init, n_mean, n_b1, n_b0, n_done;
  int   t_init, t_mean, t_b1, t_b0, t_done, t_start;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample at negedge.
  task automatic tick();
    int   nstr;
    int   kind;
    exp_t e;
    @(posedge clk);
    #1;
    reset[cur]     = reset_req;
    start[cur]     = start_req | spulse_next;
    mv_cur         = mv_next;
    mem_valid[cur] = mv_next | stray_req | extra_next;
    if (reset_req) outst = 1'b0;
    @(negedge clk);
    cyc++;
    s_busy   = busy[cur];
    s_pass   = pass_s[cur];
    s_addr   = mem_addr[cur];
    s_mem_rd = mem_rd[cur];
    s_acc    = acc_sum[cur] | acc_ss[cur] | acc_err[cur];
    nstr = int'(init_acc[cur]) + int'(acc_sum[cur]) + int'(acc_ss[cur]) +
           int'(acc_err[cur]) + int'(load_mean[cur]) + int'(load_b1[cur]) +
           int'(load_b0[cur]) + int'(done[cur]);
    chk(nstr <= 1, "strobe_exclusive", nstr, 1);
    if (spulse_chk) chk(s_pass == 2'd2 && s_busy, "start_ignored_pass", int'(s_pass), 2);
    spulse_chk = spulse_next;
    if (s_mem_rd) begin
      chk(!outst, "rd_while_outstanding", int'(outst), 0);
      outst = 1'b1;
    end
    if (mv_cur) outst = 1'b0;
    if (s_acc) begin
      kind = acc_sum[cur] ? 1 : (acc_ss[cur] ? 2 : 3);
      acc_total++;
      if (sbq.size() == 0) begin
        chk(1'b0, "acc_unexpected", kind, 0);
      end else begin
        e = sbq.pop_front();
        chk(kind == int'(e.p) && pass_s[cur] == e.p, "acc_pass", kind, int'(e.p));
        chk(mem_addr[cur] == e.a, "acc_addr", int'(mem_addr[cur]), int'(e.a));
      end
      if (kind == 1) c_sum++;
      else if (kind == 2) c_ss++;
      else c_err++;
    end
    if (init_acc[cur])  begin n_init++; t_init = cyc; end
    if (load_mean[cur]) begin n_mean++; t_mean = cyc; end
    if (load_b1[cur])   begin n_b1++;   t_b1   = cyc; end
    if (load_b0[cur])   begin n_b0++;   t_b0   = cyc; end
    if (done[cur])      begin n_done++; t_done = cyc; end
    // Memory: a read seen in cycle c returns data in cycle c+L.
    if (s_mem_rd) cd = int'($urandom_range(lmax, lmin));
    if (cd > 0) begin
      cd--;
      mv_next = (cd == 0);
    end else begin
      mv_next = 1'b0;
    end
    // The cycle after any strobe is never WAIT, so a stray valid there must be ignored.
    extra_next  = stray_auto && (nstr != 0);
    spulse_next = start_auto && acc_ss[cur] && (mem_addr[cur] == AW'(40));
  endtask

  task automatic push_run(input int n);
    for (int p = 1; p <= 3; p++) begin
      for (int a = 0; a < n; a++) begin
        exp_t e;
        e.p = 2'(p);
        e.a = AW'(a);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic check_idle(input int i, input string name);
    logic [19:0] v;
    v = {mem_rd[i], init_acc[i], acc_sum[i], acc_ss[i], acc_err[i], load_mean[i],
         load_b1[i], load_b0[i], done[i], busy[i], pass_s[i], mem_addr[i]};
    chk(v == 20'd0, name, int'(v), 0);
  endtask

  task automatic run(input vec_t v, input bit hold);
    int budget;
    bit seen;
    cur = v.inst; lmin = v.lmin; lmax = v.lmax;
    stray_auto = (v.stray != 0);
    start_auto = (v.stray != 0);
    push_run(v.n);
    c_sum = 0; c_ss = 0; c_err = 0; n_init = 0; n_mean = 0; n_b1 = 0; n_b0 = 0; n_done = 0;
    t_init = 0; t_mean = 0; t_b1 = 0; t_b0 = 0; t_done = 0;
    start_req = 1'b1;
    tick();
    t_start = cyc;
    chk(!s_busy, "start_in_idle", int'(s_busy), 0);
    if (!hold) start_req = 1'b0;
    budget = 3 * v.n * (v.lmax + 1) + 40;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (n_done != 0) seen = 1'b1;
    end
    chk(seen, "done_timeout", int'(seen), 1);
    if (v.exp_lat >= 0) chk(t_done - t_init + 1 == v.exp_lat, "done_latency", t_done - t_init + 1, v.exp_lat);
    chk(n_init == 1 && t_init == t_start + 1, "init_after_start", t_init - t_start, 1);
    chk(c_sum == v.n, "count_acc_sum", c_sum, v.n);
    chk(c_ss == v.n, "count_acc_ss", c_ss, v.n);
    chk(c_err == v.n, "count_acc_err", c_err, v.n);
    chk(n_mean == 1 && n_b1 == 1 && n_b0 == 1, "load_pulses", n_mean + n_b1 + n_b0, 3);
    chk(t_mean < t_b1, "mean_before_b1", t_b1 - t_mean, 1);
    chk(t_b0 == t_b1 + 1, "b0_after_b1", t_b0 - t_b1, 1);
    chk(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
    sbq.delete();
    stray_auto = 1'b0;
    start_auto = 1'b0;
    if (!hold) begin
      tick();
      chk(!s_busy && s_pass == 2'd0, "idle_after_done", int'({s_busy, s_pass}), 0);
    end
  endtask

  vec_t tbl [7];
  vec_t row;
  int   d, acc0;
  bit   found;

  initial begin
    tbl[0] = '{0, 150, 1, 1,  905, 0};  // nominal, 6N+5
    tbl[1] = '{0, 150, 1, 5,   -1, 0};  // random latency
    tbl[2] = '{1,   1, 1, 1,   11, 0};  // N=1
    tbl[3] = '{2, 256, 1, 1, 1541, 0};  // full address space, no wrap
    tbl[4] = '{2, 256, 2, 2, 2309, 0};  // L=2: 3N(L+1)+5
    tbl[5] = '{1,   1, 1, 4,   -1, 0};
    tbl[6] = '{0, 150, 1, 1,  905, 1};  // stray valid/start, timing unchanged

    cur = 0; lmin = 1; lmax = 1; cyc = 0; cd = 0; acc_total = 0;
    mv_next = 1'b0; mv_cur = 1'b0; extra_next = 1'b0; spulse_next = 1'b0; spulse_chk = 1'b0;
    stray_req = 1'b0; stray_auto = 1'b0; start_auto = 1'b0; start_req = 1'b0; outst = 1'b0;
    reset_req = 1'b0;
    for (int i = 0; i < NI; i++) begin
      reset[i] = 1'b1; start[i] = 1'b0; mem_valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i, "reset_state");
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) reset[i] = 1'b0;

    // Stray valid in IDLE.
    stray_req = 1'b1;
    tick();
    chk(!s_acc, "idle_stray_acc", int'(s_acc), 0);
    stray_req = 1'b0;
    tick();
    chk(!s_busy, "idle_stray_state", int'(s_busy), 0);

    for (int r = 0; r < 7; r++) run(tbl[r], 1'b0);

    // Reset while pass 2 waits on address 73, then a late mem_valid.
    cur = 0; lmin = 4; lmax = 4;
    push_run(150);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick();
      if (s_mem_rd && s_pass == 2'd2 && s_addr == AW'(73)) found = 1'b1;
    end
    chk(found, "reach_pass2_addr73", int'(found), 1);
    reset_req = 1'b1;
    tick();
    chk(s_busy && s_pass == 2'd2, "reset_in_wait", int'(s_pass), 2);
    reset_req = 1'b0;
    sbq.delete();
    tick();
    check_idle(0, "after_mid_reset");
    acc0 = acc_total;
    repeat (6) tick();
    chk(acc_total == acc0, "late_valid_ignored", acc_total - acc0, 0);
    chk(!s_busy, "late_valid_state", int'(s_busy), 0);
    run(tbl[0], 1'b0);

    // Start held high: END3, IDLE, INIT.
    run(tbl[0], 1'b1);
    d = t_done;
    run(tbl[0], 1'b0);
    chk(t_init == d + 2, "b2b_init_gap", t_init - d, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
